// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants and encodings for the VGA video-RAM path
package vga_pkg;

    localparam int FRAME_CLKS = 833600;
    localparam int LINE_CLKS  = 1600;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 3;

    // One-hot return tag {DISP, DRAW_RD}; writes travel untagged.
    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_DRAW = 2'b01,
        TAG_DISP = 2'b10
    } tag_e;

    typedef enum logic {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_e;

endpackage

// File: rtl/vga_vram_tagpipe.sv
// rtl/vga_vram_tagpipe.sv - two-stage read tag pipeline and return-data steering
module vga_vram_tagpipe
    import vga_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  tag_e              tag_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              disp_valid_o,
    output logic [DATA_W-1:0] disp_rdata_o,
    output logic              draw_rvalid_o,
    output logic [DATA_W-1:0] draw_rdata_o
);

    tag_e              stage1_q;
    tag_e              stage2_q;
    logic [DATA_W-1:0] disp_hold_q;
    logic [DATA_W-1:0] draw_hold_q;

    // Stage 2 lines up with the RAM read data, so steering is purely combinational.
    assign disp_valid_o  = (stage2_q == TAG_DISP);
    assign draw_rvalid_o = (stage2_q == TAG_DRAW);
    assign disp_rdata_o  = disp_valid_o  ? mem_rdata_i : disp_hold_q;
    assign draw_rdata_o  = draw_rvalid_o ? mem_rdata_i : draw_hold_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage1_q    <= TAG_NONE;
            stage2_q    <= TAG_NONE;
            disp_hold_q <= '0;
            draw_hold_q <= '0;
        end else begin
            stage1_q    <= tag_i;
            stage2_q    <= stage1_q;
            disp_hold_q <= disp_rdata_o;
            draw_hold_q <= draw_rdata_o;
        end
    end

endmodule

// File: rtl/vga_vram_arbiter.sv
// rtl/vga_vram_arbiter.sv - scan-out/draw arbiter for a double-banked video RAM
module vga_vram_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              draw_req,
    input  logic              draw_we,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [DATA_W-1:0] draw_wdata,
    output logic              draw_gnt,
    output logic              draw_rvalid,
    output logic [DATA_W-1:0] draw_rdata,
    input  logic              swap_req,
    output logic              swap_done,
    output logic              disp_bank,
    output logic              draw_starve,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    swap_state_e       swap_q, swap_d;
    logic              disp_bank_q, disp_bank_d;
    logic              swap_done_q, swap_done_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic              starve_q, starve_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    tag_e              tag_d;
    logic              swap_pending;

    assign swap_pending = (swap_q == SWAP_PENDING);
    assign draw_gnt     = draw_req & ~disp_req & ~swap_pending & ~reset;

    always_comb begin
        swap_d      = swap_q;
        disp_bank_d = disp_bank_q;
        swap_done_d = 1'b0;
        case (swap_q)
            SWAP_IDLE: begin
                // A request coinciding with frame_start only arms the flip.
                if (swap_req) swap_d = SWAP_PENDING;
            end
            SWAP_PENDING: begin
                if (frame_start) begin
                    swap_d      = SWAP_IDLE;
                    disp_bank_d = ~disp_bank_q;
                    swap_done_d = 1'b1;
                end
            end
        endcase
    end

    // Banks are resolved from next-state so the first fetch of a new frame sees the flip.
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tag_d       = TAG_NONE;
        if (disp_req) begin
            mem_en_d   = 1'b1;
            mem_addr_d = {disp_bank_d, disp_addr};
            tag_d      = TAG_DISP;
        end else if (draw_gnt) begin
            mem_en_d   = 1'b1;
            mem_we_d   = draw_we;
            mem_addr_d = {~disp_bank_d, draw_addr};
            if (draw_we) mem_wdata_d = draw_wdata;
            else         tag_d       = TAG_DRAW;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (draw_gnt)
            wait_d = '0;
        else if (draw_req && !swap_pending && wait_q != CNT_W'(STARVE_MAX))
            wait_d = wait_q + 1'b1;
        starve_d = starve_q | (wait_d == CNT_W'(STARVE_MAX));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            swap_q      <= SWAP_IDLE;
            disp_bank_q <= 1'b0;
            swap_done_q <= 1'b0;
            wait_q      <= '0;
            starve_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            swap_q      <= swap_d;
            disp_bank_q <= disp_bank_d;
            swap_done_q <= swap_done_d;
            wait_q      <= wait_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign swap_done   = swap_done_q;
    assign disp_bank   = disp_bank_q;
    assign draw_starve = starve_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

    vga_vram_tagpipe #(
        .DATA_W (DATA_W)
    ) u_tagpipe (
        .clk           (clk),
        .reset         (reset),
        .tag_i         (tag_d),
        .mem_rdata_i   (mem_rdata),
        .disp_valid_o  (disp_valid),
        .disp_rdata_o  (disp_rdata),
        .draw_rvalid_o (draw_rvalid),
        .draw_rdata_o  (draw_rdata)
    );

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// tb/tb_vga_vram_arbiter.sv - scoreboard bench for vga_vram_arbiter
module tb_vga_vram_arbiter;

    localparam int STARVE_MAX = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        disp_req = 1'b0;
    logic [14:0] disp_addr = '0;
    logic        disp_valid;
    logic [2:0]  disp_rdata;
    logic        draw_req = 1'b0;
    logic        draw_we = 1'b0;
    logic [14:0] draw_addr = '0;
    logic [2:0]  draw_wdata = '0;
    logic        draw_gnt;
    logic        draw_rvalid;
    logic [2:0]  draw_rdata;
    logic        swap_req = 1'b0;
    logic        swap_done;
    logic        disp_bank;
    logic        draw_starve;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [2:0]  mem_wdata;
    logic [2:0]  mem_rdata = '0;

    vga_vram_arbiter #(
        .ADDR_W     (15),
        .DATA_W     (3),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_valid  (disp_valid),
        .disp_rdata  (disp_rdata),
        .draw_req    (draw_req),
        .draw_we     (draw_we),
        .draw_addr   (draw_addr),
        .draw_wdata  (draw_wdata),
        .draw_gnt    (draw_gnt),
        .draw_rvalid (draw_rvalid),
        .draw_rdata  (draw_rdata),
        .swap_req    (swap_req),
        .swap_done   (swap_done),
        .disp_bank   (disp_bank),
        .draw_starve (draw_starve),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [2:0] data;
    } exp_t;

    exp_t       disp_q[$];
    exp_t       draw_q[$];
    logic [2:0] ram     [0:65535];
    logic [2:0] ref_mem [0:65535];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    // Reference state: what the outputs should show after the latest edge.
    logic        m_bank, m_pending, m_done, m_starve, m_en, m_we, last_gnt;
    logic [15:0] m_addr;
    logic [2:0]  m_wdata;
    int          m_wait;
    logic [2:0]  last_disp, last_draw;
    logic        mon_exp;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        logic        flip, bank_now, gnt;
        logic [15:0] a;
        if (reset) begin
            m_bank = 0; m_pending = 0; m_done = 0; m_starve = 0; m_wait = 0;
            m_en = 0; m_we = 0; m_addr = '0; m_wdata = '0; last_gnt = 0;
            return;
        end
        chk("disp_bank", disp_bank, m_bank);
        chk("swap_done", swap_done, m_done);
        chk("draw_starve", draw_starve, m_starve);
        chk("mem_en", mem_en, m_en);
        chk("mem_we", mem_we, m_we);
        if (m_en) chk("mem_addr", mem_addr, m_addr);
        if (m_en && m_we) chk("mem_wdata", mem_wdata, m_wdata);

        flip     = m_pending && frame_start;
        bank_now = m_bank ^ flip;
        gnt      = draw_req && !disp_req && !m_pending;
        chk("draw_gnt", draw_gnt, gnt);

        m_en = 0;
        m_we = 0;
        if (disp_req) begin
            a = {bank_now, disp_addr};
            m_en = 1; m_addr = a;
            disp_q.push_back('{cyc + 2, ref_mem[a]});
        end else if (gnt) begin
            a = {~bank_now, draw_addr};
            m_en = 1; m_we = draw_we; m_addr = a;
            if (draw_we) begin
                ref_mem[a] = draw_wdata;
                m_wdata    = draw_wdata;
            end else begin
                draw_q.push_back('{cyc + 2, ref_mem[a]});
            end
        end

        if (gnt) m_wait = 0;
        else if (draw_req && !m_pending && m_wait < STARVE_MAX) m_wait++;
        if (m_wait >= STARVE_MAX) m_starve = 1;

        m_done = flip;
        if (flip) begin
            m_bank    = ~m_bank;
            m_pending = 0;
        end else if (swap_req) begin
            m_pending = 1;
        end
        last_gnt = gnt;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            disp_q.delete();
            draw_q.delete();
            last_disp = '0;
            last_draw = '0;
            chk("reset_outputs", {disp_valid, disp_rdata, draw_gnt, draw_rvalid, draw_rdata,
                                  swap_done, disp_bank, draw_starve, mem_en, mem_we,
                                  mem_addr, mem_wdata}, 64'd0);
        end else begin
            mon_exp = (disp_q.size() > 0) && (disp_q[0].due == cyc);
            if (disp_valid || mon_exp) begin
                chk("disp_valid", disp_valid, mon_exp);
                if (mon_exp) begin
                    chk("disp_rdata", disp_rdata, disp_q[0].data);
                    last_disp = disp_q[0].data;
                    void'(disp_q.pop_front());
                end
            end else begin
                chk("disp_rdata_hold", disp_rdata, last_disp);
            end
            mon_exp = (draw_q.size() > 0) && (draw_q[0].due == cyc);
            if (draw_rvalid || mon_exp) begin
                chk("draw_rvalid", draw_rvalid, mon_exp);
                if (mon_exp) begin
                    chk("draw_rdata", draw_rdata, draw_q[0].data);
                    last_draw = draw_q[0].data;
                    void'(draw_q.pop_front());
                end
            end else begin
                chk("draw_rdata_hold", draw_rdata, last_draw);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        disp_req = 0; draw_req = 0; draw_we = 0; swap_req = 0; frame_start = 0;
    endtask

    task automatic new_draw();
        draw_req   = ($urandom_range(0, 3) != 0);
        draw_we    = $urandom_range(0, 1);
        draw_addr  = 15'($urandom_range(0, 63));
        draw_wdata = 3'($urandom_range(0, 7));
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i]     = 3'($urandom_range(0, 7));
            ref_mem[i] = ram[i];
        end
        @(posedge clk); #1;
        step(); step();
        reset = 0;
        step();

        // Contention: display wins, draw goes next cycle to the other bank.
        disp_req = 1; disp_addr = 15'h0010;
        draw_req = 1; draw_we = 0; draw_addr = 15'h0abc;
        step();
        disp_req = 0;
        step();
        idle_inputs();

        // Write then read back through the draw path.
        draw_req = 1; draw_we = 1; draw_addr = 15'h1234; draw_wdata = 3'b101;
        step();
        draw_we = 0;
        step();
        idle_inputs();
        repeat (3) step();

        // Reset landing while a read is in flight.
        draw_req = 1; draw_we = 0; draw_addr = 15'h0042;
        disp_addr = 15'h0007;
        step();
        idle_inputs();
        reset = 1;
        step(); step();
        reset = 0;
        repeat (4) step();

        // Swap with a held draw request blocked until the flip.
        draw_req = 1; draw_we = 0; draw_addr = 15'h0100;
        swap_req = 1;
        step();
        swap_req = 0;
        repeat (39) step();
        frame_start = 1;
        step();
        frame_start = 0;
        repeat (3) step();
        idle_inputs();

        // swap_req coincident with frame_start arms only; next frame_start flips.
        swap_req = 1; frame_start = 1;
        step();
        swap_req = 0; frame_start = 0;
        disp_req = 1; disp_addr = 15'h0020;
        repeat (5) step();
        frame_start = 1;
        step();
        idle_inputs();
        disp_req = 1;
        repeat (3) step();
        idle_inputs();

        for (int i = 0; i < 3000; i++) begin
            if (last_gnt || !draw_req) new_draw();
            disp_req    = ($urandom_range(0, 1) == 1);
            disp_addr   = 15'($urandom_range(0, 63));
            swap_req    = ($urandom_range(0, 49) == 0);
            frame_start = ($urandom_range(0, 79) == 0);
            step();
        end
        idle_inputs();
        frame_start = 1;
        step();
        frame_start = 0;
        repeat (3) step();

        // Starvation: display holds the RAM for 70 cycles against a waiting draw.
        draw_req = 1; draw_we = 0; draw_addr = 15'h0003;
        disp_req = 1;
        repeat (70) step();
        disp_req = 0;
        step();
        idle_inputs();
        repeat (5) step();
        chk("queues_drained", disp_q.size() + draw_q.size(), 0);

        reset = 1;
        step();
        reset = 0;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/vga_vram_arbiter.md
# vga_vram_arbiter

Shares one single-port, double-banked video RAM between two requesters: the VGA scan-out fetch path (hard real-time) and a drawing engine (best-effort read/write). The block sits between the sync-timing logic and the video RAM. It arbitrates every clock cycle, runs a fixed-latency read-return pipeline, and flips the displayed bank at frame boundaries on request.

## Interface
Parameters:
- ADDR_W, 15, word address width within one bank (160x120 framebuffer = 19200 words)
- DATA_W, 3, pixel word width (R,G,B)
- STARVE_MAX, 64, consecutive cycles a pending draw request may wait before draw_starve sets

Ports:
- clk  in  1  system clock (50 MHz; one pixel per 2 clocks)
- reset  in  1  asynchronous, active-high; all state and outputs cleared immediately
- frame_start  in  1  one-cycle pulse at the first clock of each frame (vsync counter wrap)
- disp_req  in  1  scan-out read request; never stalled
- disp_addr  in  ADDR_W  scan-out word address
- disp_valid  out  1  disp_rdata valid
- disp_rdata  out  DATA_W  scan-out read data
- draw_req  in  1  draw access request; held with stable fields until granted
- draw_we  in  1  1 = write, 0 = read
- draw_addr  in  ADDR_W  draw word address
- draw_wdata  in  DATA_W  draw write data
- draw_gnt  out  1  combinational one-cycle accept pulse
- draw_rvalid  out  1  draw_rdata valid (reads only)
- draw_rdata  out  DATA_W  draw read data
- swap_req  in  1  pulse; request a bank flip at the next frame_start
- swap_done  out  1  one-cycle pulse in the cycle the flip takes effect
- disp_bank  out  1  bank currently scanned out
- draw_starve  out  1  sticky; cleared only by reset
- mem_en, mem_we  out  1 each  RAM strobe and write enable
- mem_addr  out  ADDR_W+1  {bank, word address}
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after a read strobe

## Operation
- Arbitration is evaluated each cycle. Priority:
  - disp_req wins.
  - Otherwise draw_req is granted if swap_pending = 0.
  - Otherwise idle.
- draw_gnt = draw_req & !disp_req & !swap_pending.
- The display accesses bank disp_bank. The draw path accesses bank ~disp_bank.
- Accepted requests are registered onto mem_*. An idle cycle drives mem_en = 0 and mem_we = 0. mem_addr and mem_wdata hold their last values.
- Tag pipeline: 2-bit tag {DISP, DRAW_RD}, 2 stages deep. A write carries no tag.
- Returned data is steered to disp_rdata/disp_valid or draw_rdata/draw_rvalid according to the tag. The rdata outputs hold between valids.
- Swap control:
  - A swap_req pulse sets swap_pending.
  - At a later frame_start with swap_pending = 1: disp_bank toggles, swap_pending clears, swap_done pulses.
  - If swap_req and frame_start arrive in the same cycle, only pending is set. The flip happens at the following frame_start.
  - A swap_req while already pending is ignored.
- Starvation: a wait counter increments each cycle that draw_req = 1 and draw_gnt = 0, and clears on grant.
  - Reaching STARVE_MAX sets draw_starve.
  - The counter saturates and does not wrap.
  - Cycles blocked by swap_pending do not count.

## Timing
- Reset values: every output is 0, disp_bank = 0, swap_pending = 0, tags cleared. The pipeline is flushed, so no valid appears after reset release from pre-reset requests.
- Accept at cycle t -> mem_* driven at t+1 -> mem_rdata at t+2 -> disp_valid or draw_rvalid at t+2. This is combinational steering from the registered tag, so the latency is fixed at 2 cycles.
- Back-to-back accepts are allowed every cycle. Throughput is 1 access per cycle.
- The flip occurs at the frame_start edge. The first display access of the new frame, in that same cycle, already uses the new bank. disp_bank updates registered at t+1, and the arbiter uses the next-state value.
- Draw requests that are already in flight when the swap takes effect complete to their original bank, because the bank is latched at accept.

## Structure
- Shared package vga_pkg holds:
  - frame constants: FRAME_CLKS = 833600, LINE_CLKS = 1600
  - default ADDR_W and DATA_W
  - tag encoding: TAG_NONE, TAG_DISP, TAG_DRAW
- One natural sub-module, vga_vram_tagpipe: the 2-stage tag shift register plus rdata steering.
- The arbiter, swap FSM (IDLE/PENDING) and starvation counter live in the top module.

## Test plan
- Reset mid-read: read accepted at t, reset asserted at t+1 -> no disp_valid or draw_rvalid. All outputs are 0 while reset is high.
- Contention: disp_req and draw_req high on the same cycle, disp_addr = 0x0010 -> mem_addr = {0, 0x0010} at t+1 and draw_gnt = 0. The draw is granted the next cycle, when disp_req = 0, with mem_addr = {1, draw_addr}.
- Draw write then read of 0x1234 with data 3'b101 -> draw_rvalid 2 cycles after the read grant, draw_rdata = 3'b101. disp_valid stays low throughout.
- Swap: swap_req at cycle 10, frame_start at cycle 50 -> draw_gnt held 0 from cycles 11-50. swap_done pulses at cycle 51 and disp_bank = 1. Drawing then resumes to bank 0.
- Coincident swap_req and frame_start -> no flip on that frame_start. The flip happens on the next frame_start.
- Starvation: disp_req held high for 70 cycles with draw_req high -> draw_starve sets at the 64th waiting cycle, stays set after disp_req drops, and clears only on reset.
